// File: rtl/memn2n_pkg.sv
// Shared types and arithmetic for the MemN2N embedding bank.
// Build option: MEMN2N_EMB_SAT_EN selects saturating adds; undefined gives wrap-around.
package memn2n_pkg;

  typedef enum logic [1:0] {
    MODE_LOOKUP = 2'b00,
    MODE_UPDATE = 2'b01,
    MODE_INIT   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_LK_RD,
    ST_LK_ACC,
    ST_UP_RD,
    ST_UP_WR,
    ST_DONE
  } state_t;

  // Adds two sign-extended wl-bit operands; the caller keeps the low wl bits.
  function automatic logic [63:0] fx_add(input logic [63:0] a, input logic [63:0] b,
                                         input int wl);
`ifdef MEMN2N_EMB_SAT_EN
    logic signed [64:0] sum;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sum = $signed({a[63], a}) + $signed({b[63], b});
    hi  = (65'sd1 <<< (wl - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (wl - 1));
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return sum[63:0];
`else
    logic [63:0] mask;
    mask = (64'd1 << wl) - 64'd1;
    return (a + b) & mask;
`endif
  endfunction

endpackage

// File: rtl/emb_row_ram.sv
// Single-port synchronous weight RAM for one embedding lane, one word per row.
module emb_row_ram #(
  parameter int WL    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [WL-1:0] wdata,
  output logic [WL-1:0] rdata
);

  logic [WL-1:0] mem [DEPTH];

  // Write when enabled; the read word is registered (one cycle latency).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memn2n_emb_bank.sv
// MemN2N embedding bank: lookup (masked row sum), update (add gradient to selected
// rows) and init (fill with INIT_VAL) over DIM_EMB row-addressed RAM lanes.
// Build option: MEMN2N_EMB_SAT_EN makes every accumulate/update add saturate.
module memn2n_emb_bank
  import memn2n_pkg::*;
#(
  parameter int            DIM_IN   = 32,
  parameter int            DIM_EMB  = 16,
  parameter int            WL       = 32,
  parameter int            IWL      = 16,
  parameter logic [WL-1:0] INIT_VAL = WL'(32'h0000_0001)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DIM_IN-1:0]     data_in,
  input  logic [WL*DIM_EMB-1:0] grad_in,
  output logic                  busy,
  output logic                  done,
  output logic [WL*DIM_EMB-1:0] data_out
);

  localparam int            AW   = (DIM_IN > 1) ? $clog2(DIM_IN) : 1;
  localparam logic [AW-1:0] LAST = AW'(DIM_IN - 1);

  state_t                      state_reg, state_next;
  logic [AW-1:0]               addr_reg, addr_next;
  logic [DIM_IN-1:0]           sel_reg;
  logic [WL*DIM_EMB-1:0]       grad_reg;
  logic [DIM_EMB-1:0][WL-1:0]  acc_reg;
  logic [DIM_EMB-1:0][WL-1:0]  acc_sum;
  logic [DIM_EMB-1:0][WL-1:0]  rdata;
  logic                        rd_vld_reg;
  logic                        rd_sel_reg;
  logic                        ram_we;
  logic                        accept;

  assign accept = (state_reg == ST_IDLE) && start && (mode != MODE_RSVD);
  assign busy   = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign done   = (state_reg == ST_DONE);
  assign ram_we = (state_reg == ST_INIT) ||
                  ((state_reg == ST_UP_WR) && sel_reg[addr_reg]);

  // Next-state and address counter; completion is detected at row DIM_IN-1.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          addr_next = '0;
          if (mode == MODE_LOOKUP)      state_next = ST_LK_RD;
          else if (mode == MODE_UPDATE) state_next = ST_UP_RD;
          else                          state_next = ST_INIT;
        end
      end
      ST_INIT: begin
        if (addr_reg == LAST) state_next = ST_DONE;
        else                  addr_next  = addr_reg + 1'b1;
      end
      ST_LK_RD: begin
        if (addr_reg == LAST) state_next = ST_LK_ACC;
        else                  addr_next  = addr_reg + 1'b1;
      end
      ST_LK_ACC: state_next = ST_DONE;
      ST_UP_RD:  state_next = ST_UP_WR;
      ST_UP_WR: begin
        if (addr_reg == LAST) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_UP_RD;
          addr_next  = addr_reg + 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-lane datapath: accumulate term, update sum, write mux and RAM instance.
  for (genvar gi = 0; gi < DIM_EMB; gi++) begin : g_lane
    logic [WL-1:0] lk_term;
    logic [WL-1:0] upd_sum;
    logic [WL-1:0] wdata;

    assign lk_term     = rd_sel_reg ? rdata[gi] : '0;
    assign acc_sum[gi] = WL'(fx_add(64'($signed(acc_reg[gi])), 64'($signed(lk_term)), WL));
    assign upd_sum     = WL'(fx_add(64'($signed(rdata[gi])),
                                    64'($signed(grad_reg[gi*WL +: WL])), WL));
    assign wdata       = (state_reg == ST_INIT) ? INIT_VAL : upd_sum;

    emb_row_ram #(
      .WL    (WL),
      .DEPTH (DIM_IN),
      .AW    (AW)
    ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (addr_reg),
      .wdata (wdata),
      .rdata (rdata[gi])
    );
  end

  // State, command buffers, read-pipeline tags, accumulator and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      sel_reg    <= '0;
      grad_reg   <= '0;
      acc_reg    <= '0;
      rd_vld_reg <= 1'b0;
      rd_sel_reg <= 1'b0;
      data_out   <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      // The select bit travels with the read so it lines up with rdata.
      rd_vld_reg <= (state_reg == ST_LK_RD);
      rd_sel_reg <= (state_reg == ST_LK_RD) && sel_reg[addr_reg];
      if (accept) begin
        sel_reg  <= data_in;
        grad_reg <= grad_in;
        acc_reg  <= '0;
      end else if (rd_vld_reg) begin
        acc_reg <= acc_sum;
      end
      // LK_ACC folds in the final row while loading the result for DONE.
      if (state_reg == ST_LK_ACC) begin
        data_out <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_memn2n_emb_bank.sv
// Scoreboard bench for memn2n_emb_bank: the driver pushes expected completion cycle
// and lookup result from an array-based weight model; a monitor checks each done.
module tb_memn2n_emb_bank;

  localparam int          DIM_IN   = 8;
  localparam int          DIM_EMB  = 4;
  localparam int          WL       = 16;
  localparam logic [15:0] INIT_VAL = 16'h0001;
  localparam int          NB       = WL * DIM_EMB;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [7:0]    data_in;
  logic [NB-1:0] grad_in;
  wire           busy;
  wire           done;
  wire [NB-1:0]  data_out;

  memn2n_emb_bank #(
    .DIM_IN   (DIM_IN),
    .DIM_EMB  (DIM_EMB),
    .WL       (WL),
    .IWL      (8),
    .INIT_VAL (INIT_VAL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .data_in  (data_in),
    .grad_in  (grad_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    bit            is_lk;
    logic [NB-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   w[DIM_IN][DIM_EMB];

  // Reference add on signed integers: clamp or wrap to WL bits.
  function automatic int fadd(input int a, input int b);
    int s;
    s = a + b;
`ifdef MEMN2N_EMB_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`else
    s = ((s + 32768) & 65535) - 32768;
`endif
    return s;
  endfunction

  function automatic int sx16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [NB-1:0] rep(input logic [15:0] v);
    return {DIM_EMB{v}};
  endfunction

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done_at_cyc_%0d required=no_done", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", NB'(cyc), NB'(e.cyc));
        check("busy_in_done", NB'(busy), NB'(0));
        if (e.is_lk) check("lookup_data", data_out, e.data);
        $display("txn done cyc=%0d kind=%s data_out=%h", cyc, e.is_lk ? "lookup" : "write",
                 data_out);
      end
    end
  end

  // Drive one command in the next cycle and push its expectation from the model.
  task automatic issue(input logic [1:0] m, input logic [7:0] d, input logic [NB-1:0] g);
    exp_t e;
    int   acc;
    @(negedge clk);
    e.is_lk = (m == 2'b00);
    e.data  = '0;
    case (m)
      2'b00: begin
        e.cyc = cyc + DIM_IN + 2;
        for (int i = 0; i < DIM_EMB; i++) begin
          acc = 0;
          for (int r = 0; r < DIM_IN; r++) if (d[r]) acc = fadd(acc, w[r][i]);
          e.data[i*WL +: WL] = acc[15:0];
        end
      end
      2'b01: begin
        e.cyc = cyc + 2 * DIM_IN + 1;
        for (int r = 0; r < DIM_IN; r++)
          if (d[r]) for (int i = 0; i < DIM_EMB; i++) w[r][i] = fadd(w[r][i], sx16(g[i*WL +: WL]));
      end
      default: begin
        e.cyc = cyc + DIM_IN + 1;
        for (int r = 0; r < DIM_IN; r++)
          for (int i = 0; i < DIM_EMB; i++) w[r][i] = sx16(INIT_VAL);
      end
    endcase
    sb.push_back(e);
    start   = 1'b1;
    mode    = m;
    data_in = d;
    grad_in = g;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", NB'(busy), NB'(1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=pending_%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [1:0] m, input logic [7:0] d, input logic [NB-1:0] g);
    issue(m, d, g);
    wait_done();
  endtask

  initial begin
    logic [NB-1:0] g;
    int            k;
    rst     = 1'b1;
    start   = 1'b0;
    mode    = 2'b00;
    data_in = '0;
    grad_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", NB'(busy), NB'(0));
    check("reset_done", NB'(done), NB'(0));
    check("reset_data_out", data_out, '0);
    rst = 1'b0;

    // Directed sequence.
    run(2'b10, 8'h00, '0);
    run(2'b00, 8'hB1, '0);
    run(2'b01, 8'h03, rep(16'h0002));
    run(2'b00, 8'h03, '0);
    run(2'b00, 8'h04, '0);
    run(2'b00, 8'h00, '0);

    // Reserved mode in IDLE: nothing starts, no done.
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b11;
    @(negedge clk);
    start = 1'b0;
    check("reserved_busy", NB'(busy), NB'(0));
    repeat (12) @(negedge clk);

    // A start pulse in cycle 3 of a lookup is ignored.
    issue(2'b00, 8'hB1, '0);
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b10;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    run(2'b00, 8'hB1, '0);

    // Reset in the middle of a lookup.
    run(2'b10, 8'h00, '0);
    issue(2'b00, 8'hFF, '0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", NB'(busy), NB'(0));
    check("midrst_done", NB'(done), NB'(0));
    check("midrst_data_out", data_out, '0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    run(2'b00, 8'h01, '0);

    // Overflow: rows reach 16'h7000, their sum clips or wraps.
    run(2'b10, 8'h00, '0);
    run(2'b01, 8'hFF, rep(16'h6FFF));
    run(2'b00, 8'hFF, '0);

    // Randomized mix.
    run(2'b10, 8'h00, '0);
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      for (int i = 0; i < DIM_EMB; i++)
        g[i*WL +: WL] = (k < 3) ? 16'($urandom) : 16'($urandom_range(0, 15) - 8);
      if (k == 0)      run(2'b10, 8'h00, '0);
      else if (k < 5)  run(2'b01, 8'($urandom), g);
      else             run(2'b00, 8'($urandom), '0);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
